// File: rtl/xpb_pkg.sv
// Shared defaults, state encoding and table sizing for the xpb table generator.
package xpb_pkg;

  localparam int WIDTH_DEF    = 1024;
  localparam int SEL_BITS_DEF = 5;
  localparam int SHIFT_W_DEF  = 11;
  localparam int TABLE_DEPTH  = 1 << SEL_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POW  = 2'd1,
    EMIT = 2'd2
  } state_t;

  function automatic int table_depth(input int sel_bits);
    return 1 << sel_bits;
  endfunction

endpackage

// File: rtl/xpb_mod_addsub.sv
// Combinational modular add: y = (a + b) mod n, valid when a, b < n.
module xpb_mod_addsub #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit keeps the carry so the compare against n is exact.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = sum - {1'b0, n};
  assign y    = (sum >= {1'b0, n}) ? diff[WIDTH-1:0] : sum[WIDTH-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// Computes B = 2^S mod N by repeated doubling, then streams j*B mod N for every
// table index j over a valid/ready port.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int SEL_BITS = SEL_BITS_DEF,
  parameter int SHIFT_W  = SHIFT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    modulus,
  input  logic [SHIFT_W-1:0]  shift,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SEL_BITS-1:0] out_index,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last
);

  localparam int                DEPTH  = table_depth(SEL_BITS);
  localparam logic [SEL_BITS-1:0] J_LAST = SEL_BITS'(DEPTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     n_reg;
  logic [WIDTH-1:0]     r;      // running power of two; holds B once POW ends
  logic [WIDTH-1:0]     acc;
  logic [SHIFT_W-1:0]   cnt;
  logic [SEL_BITS-1:0]  j;

  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     sum_mod;
  logic                 fire;

  // Shared adder: POW doubles r, EMIT adds B (= r) to the accumulator.
  assign op_a = (state == POW) ? r : acc;

  xpb_mod_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a (op_a),
    .b (r),
    .n (n_reg),
    .y (sum_mod)
  );

  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign out_data  = acc;
  assign out_index = j;
  assign out_last  = out_valid && (j == J_LAST);
  assign fire      = out_valid && out_ready;

  // NOTE: every register here uses <= so all updates see pre-edge values; with
  // blocking assignments the order of statements would silently change results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n_reg <= '0;
      r     <= '0;
      acc   <= '0;
      cnt   <= '0;
      j     <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (modulus < WIDTH'(2)) begin
              error <= 1'b1;
            end else begin
              n_reg <= modulus;
              r     <= WIDTH'(1);
              acc   <= '0;
              j     <= '0;
              cnt   <= shift;
              state <= (shift != '0) ? POW : EMIT;
            end
          end
        end
        POW: begin
          r   <= sum_mod;
          cnt <= cnt - SHIFT_W'(1);
          if (cnt == SHIFT_W'(1)) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (fire) begin
            acc <= sum_mod;
            j   <= j + SEL_BITS'(1);
            if (j == J_LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: 8-bit table vectors, error, backpressure,
// mid-run reset, and one 1024-bit run against a wide-arithmetic golden model.
module tb_xpb_table_gen;

  localparam int W8 = 8;
  localparam int WW = 1024;
  localparam int SB = 5;
  localparam int SW = 11;
  localparam int NENT = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic          start8 = 1'b0;
  logic [W8-1:0] mod8 = '0;
  logic [SW-1:0] shift8 = '0;
  logic          busy8, done8, err8, valid8, last8;
  logic          ready8 = 1'b0;
  logic [SB-1:0] idx8;
  logic [W8-1:0] data8;

  // 1024-bit instance
  logic          startw = 1'b0;
  logic [WW-1:0] modw = '0;
  logic [SW-1:0] shiftw = '0;
  logic          busyw, donew, errw, validw, lastw;
  logic          readyw = 1'b0;
  logic [SB-1:0] idxw;
  logic [WW-1:0] dataw;

  xpb_table_gen #(.WIDTH(W8), .SEL_BITS(SB), .SHIFT_W(SW)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .modulus(mod8), .shift(shift8),
    .busy(busy8), .done(done8), .error(err8), .out_valid(valid8),
    .out_ready(ready8), .out_index(idx8), .out_data(data8), .out_last(last8)
  );

  xpb_table_gen #(.WIDTH(WW), .SEL_BITS(SB), .SHIFT_W(SW)) dutw (
    .clk(clk), .reset(reset), .start(startw), .modulus(modw), .shift(shiftw),
    .busy(busyw), .done(donew), .error(errw), .out_valid(validw),
    .out_ready(readyw), .out_index(idxw), .out_data(dataw), .out_last(lastw)
  );

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act[191:0], exp[191:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle8(input string tag);
    check({tag, " valid"}, WW'(valid8), WW'(0));
    check({tag, " busy"},  WW'(busy8),  WW'(0));
    check({tag, " done"},  WW'(done8),  WW'(0));
    check({tag, " error"}, WW'(err8),   WW'(0));
    check({tag, " last"},  WW'(last8),  WW'(0));
    check({tag, " index"}, WW'(idx8),   WW'(0));
    check({tag, " data"},  WW'(data8),  WW'(0));
  endtask

  typedef struct {
    logic [7:0]  n;
    logic [10:0] s;
    int          b;     // hand-computed 2^s mod n
    int          e31;   // hand-computed 31*b mod n
    bit          stall;
  } vec_t;

  vec_t vecs[7];

  // Runs one full 8-bit table with either continuous or random out_ready.
  task automatic run_stream(input vec_t v);
    int lat, cyc, jj, guard, expd;
    logic [W8-1:0] hold_d;
    logic [SB-1:0] hold_i;
    logic          hold_l, stalled;
    mod8 = v.n; shift8 = v.s; start8 = 1'b1;
    tick();
    start8 = 1'b0; mod8 = 8'd5; shift8 = '0;
    cyc = 1;
    check("busy after start", WW'(busy8), WW'(1));
    lat = 1;
    while (!valid8 && lat < 3000) begin
      tick(); lat++; cyc++;
    end
    check("first valid latency", WW'(lat), WW'(v.s + 1));
    jj = 0; guard = 0; stalled = 1'b0;
    while (jj < NENT && guard < 3000) begin
      check("valid held in EMIT", WW'(valid8), WW'(1));
      if (stalled) begin
        check("stall data hold",  WW'(data8), WW'(hold_d));
        check("stall index hold", WW'(idx8),  WW'(hold_i));
        check("stall last hold",  WW'(last8), WW'(hold_l));
      end else begin
        expd = (jj * v.b) % v.n;
        check("entry data",  WW'(data8), WW'(expd));
        check("entry index", WW'(idx8),  WW'(jj));
        check("entry last",  WW'(last8), WW'(jj == NENT - 1));
        if (jj == NENT - 1) check("entry j31 hand", WW'(data8), WW'(v.e31));
      end
      ready8 = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.stall && $urandom_range(0, 3) == 0) start8 = 1'b1;
      hold_d = data8; hold_i = idx8; hold_l = last8;
      stalled = valid8 && !ready8;
      if (valid8 && ready8) jj++;
      tick(); cyc++; guard++;
      start8 = 1'b0;
    end
    check("stream completed in budget", WW'(jj), WW'(NENT));
    ready8 = 1'b0;
    if (!v.stall) check("done cycle", WW'(cyc), WW'(v.s + 33));
    check("done pulse", WW'(done8),  WW'(1));
    check("busy fell",  WW'(busy8),  WW'(0));
    check("valid fell", WW'(valid8), WW'(0));
    tick();
    check("done one cycle", WW'(done8), WW'(0));
  endtask

  initial begin
    logic [WW-1:0]   nw, bw, pw, expw;
    logic [WW+5:0]   prod;
    int              lat, jj;
    int              exp13 [10];

    vecs[0] = '{n: 8'd13,  s: 11'd4, b: 3,   e31: 2,   stall: 1'b0};
    vecs[1] = '{n: 8'd7,   s: 11'd0, b: 1,   e31: 3,   stall: 1'b0};
    vecs[2] = '{n: 8'd200, s: 11'd3, b: 8,   e31: 48,  stall: 1'b0};
    vecs[3] = '{n: 8'd255, s: 11'd8, b: 1,   e31: 31,  stall: 1'b0};
    vecs[4] = '{n: 8'd2,   s: 11'd5, b: 0,   e31: 0,   stall: 1'b0};
    vecs[5] = '{n: 8'd251, s: 11'd7, b: 128, e31: 203, stall: 1'b0};
    vecs[6] = '{n: 8'd13,  s: 11'd4, b: 3,   e31: 2,   stall: 1'b1};
    exp13 = '{0, 3, 6, 9, 12, 2, 5, 8, 11, 1};

    tick(); tick();
    check_idle8("reset");
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_stream(vecs[i]);

    // N<2 rejection
    for (int k = 0; k < 2; k++) begin
      mod8 = 8'(k); shift8 = 11'd3; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("error pulse", WW'(err8),   WW'(1));
      check("error busy",  WW'(busy8),  WW'(0));
      check("error valid", WW'(valid8), WW'(0));
      tick();
      check("error one cycle", WW'(err8),  WW'(0));
      check("error no busy",   WW'(busy8), WW'(0));
      check("error no done",   WW'(done8), WW'(0));
    end

    // Reset during POW
    mod8 = 8'd13; shift8 = 11'd4; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle8("reset in POW");

    // Reset at j=10 in EMIT, checking the hand stream on the way
    mod8 = 8'd13; shift8 = 11'd4; start8 = 1'b1; ready8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (!valid8 && lat < 100) begin tick(); lat++; end
    check("pre-reset latency", WW'(lat), WW'(5));
    jj = 0;
    while (jj < 10 && valid8) begin
      check("hand stream N13", WW'(data8), WW'(exp13[jj]));
      tick(); jj++;
    end
    ready8 = 1'b0;
    check("at j10 index", WW'(idx8), WW'(10));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle8("reset in EMIT");
    run_stream(vecs[0]);

    // 1024-bit run against wide golden arithmetic
    for (int w = 0; w < WW / 32; w++) nw[w*32 +: 32] = $urandom;
    nw[WW-1] = 1'b1;
    nw[0]    = 1'b1;
    pw = '0;
    pw[620] = 1'b1;
    bw = pw % nw;
    modw = nw; shiftw = 11'd620; startw = 1'b1; readyw = 1'b1;
    tick();
    startw = 1'b0;
    lat = 1;
    while (!validw && lat < 2000) begin tick(); lat++; end
    check("wide latency", WW'(lat), WW'(621));
    for (int k = 0; k < NENT; k++) begin
      prod = (WW+6)'(k) * {6'd0, bw};
      expw = WW'(prod % {6'd0, nw});
      check("wide valid", WW'(validw), WW'(1));
      check("wide index", WW'(idxw), WW'(k));
      check("wide data",  dataw, expw);
      tick();
    end
    check("wide done", WW'(donew), WW'(1));
    readyw = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
